// File: rtl/fp_arith_pkg.sv
// Shared FP-datapath arithmetic constants, FSM state type and chunk-count helper
// for the sequential 53-8 subtractor.
package fp_arith_pkg;

  function automatic int unsigned calc_nchunk(input int unsigned a_w, input int unsigned c_w);
    return (a_w + c_w - 1) / c_w;
  endfunction

  localparam int unsigned A_W     = 53;
  localparam int unsigned B_W     = 8;
  localparam int unsigned CHUNK_W = 14;
  localparam int unsigned NCHUNK  = calc_nchunk(A_W, CHUNK_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_chunk_borrow.sv
// Combinational W-bit subtractor slice with borrow in/out.
module sub_chunk_borrow #(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    d    = full[W-1:0];
    bout = full[W];
  end

endmodule

// File: rtl/custom_subtractor53_8_seq.sv
// Multi-cycle unsigned subtractor diff = a - zext(b), one CHUNK_W slice per cycle.
// Optional build macro SUB_SATURATE_EN clamps an underflowed result to zero.
import fp_arith_pkg::*;

module custom_subtractor53_8_seq (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] diff,
  output logic           borrow,
  output logic           zero
);

  localparam int unsigned PAD_W = NCHUNK * CHUNK_W;
  localparam int unsigned IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             state_q;
  logic [PAD_W-1:0]   a_q, b_q, work_q, work_n;
  logic [IDX_W-1:0]   idx_q;
  logic               chain_q;
  logic [CHUNK_W-1:0] x_s, y_s, d_s;
  logic               bout_s;
  logic               last_s;
  int unsigned        sh;

  // Operands are zero-padded to whole slices; padding cannot change the final
  // borrow, and the padded top bits of the last slice are simply dropped.
  always_comb begin
    sh     = CHUNK_W * 32'(idx_q);
    x_s    = CHUNK_W'(a_q >> sh);
    y_s    = CHUNK_W'(b_q >> sh);
    work_n = (work_q & ~({{(PAD_W-CHUNK_W){1'b0}}, {CHUNK_W{1'b1}}} << sh))
           | ({{(PAD_W-CHUNK_W){1'b0}}, d_s} << sh);
    last_s = (idx_q == IDX_W'(NCHUNK - 1));
  end

  sub_chunk_borrow #(.W(CHUNK_W)) u_slice (
    .x    (x_s),
    .y    (y_s),
    .bin  (chain_q),
    .d    (d_s),
    .bout (bout_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      idx_q     <= '0;
      chain_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= PAD_W'(a);
            b_q      <= PAD_W'(b);
            work_q   <= '0;
            chain_q  <= 1'b0;
            idx_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_n;
          chain_q <= bout_s;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_s) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            borrow    <= bout_s;
            diff      <= work_n[A_W-1:0];
            zero      <= (work_n[A_W-1:0] == '0);
`ifdef SUB_SATURATE_EN
            if (bout_s) begin
              diff <= '0;
              zero <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_subtractor53_8_seq.sv
// Self-checking bench for custom_subtractor53_8_seq: directed and random operands
// against an arithmetic reference, plus reset-abort and backpressure scenarios.
module tb_custom_subtractor53_8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [52:0] a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [52:0] diff;
  logic        borrow;
  logic        zero;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  custom_subtractor53_8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on wide integers.
  task automatic model(input logic [52:0] ma, input logic [7:0] mb,
                       output logic [52:0] md, output logic mbo, output logic mz);
    longint unsigned wa, wb, r;
    wa  = 64'(ma);
    wb  = 64'(mb);
    mbo = (wa < wb);
    r   = (wa - wb) & ((64'd1 << 53) - 64'd1);
`ifdef SUB_SATURATE_EN
    if (mbo) r = 0;
`endif
    md = r[52:0];
    mz = (r == 0);
  endtask

  // Accept on the next edge, then measure latency and check the result.
  task automatic run_op(input string tag, input logic [52:0] ta, input logic [7:0] tb);
    logic [52:0] ed;
    logic        eb, ez;
    int          lat;
    model(ta, tb, ed, eb, ez);
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd4);
    chk({tag, ".diff"}, 64'(diff), 64'(ed));
    chk({tag, ".borrow"}, 64'(borrow), 64'(eb));
    chk({tag, ".zero"}, 64'(zero), 64'(ez));
    chk({tag, ".busy"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [52:0] ra, ed2, d_hold;
    logic [7:0]  rb;
    logic        eb2, ez2;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.diff", 64'(diff), 64'd0);
    chk("rst.borrow", 64'(borrow), 64'd0);
    chk("rst.zero", 64'(zero), 64'd0);
    rst = 1'b0;

    run_op("basic", 53'h1000, 8'h01);
    run_op("xchunk", 53'h4000, 8'h01);
    run_op("underflow", 53'h05, 8'hFF);
    run_op("equal", 53'hAB, 8'hAB);
    run_op("bzero", 53'h1F_1234_5678_9ABC, 8'h00);
    run_op("allones", 53'h1F_FFFF_FFFF_FFFF, 8'hFF);
    run_op("ripple", 53'h10_0000_0000_0000, 8'h01);

    for (int i = 0; i < 24; i++) begin
      ra = 53'({$urandom, $urandom});
      if (i % 4 == 0) ra = 53'($urandom_range(0, 300));
      rb = 8'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb);
    end

    // Reset in the middle of RUN aborts with no output.
    @(negedge clk);
    a = 53'h77; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.out_valid", 64'(out_valid), 64'd0);
    chk("rstmid.in_ready", 64'(in_ready), 64'd1);
    chk("rstmid.diff", 64'(diff), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid.no_output", 64'(out_valid), 64'd0);
    run_op("after_rst", 53'h1_0000_0000, 8'h80);

    // Backpressure: result held while a second operand waits.
    model(53'h3000, 8'h10, ed2, eb2, ez2);
    @(negedge clk);
    a = 53'h2_0000; b = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 53'h3000; b = 8'h10;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 64'(lat), 64'd4);
    chk("bp.first_diff", 64'(diff), 64'h1_FFFD);
    d_hold = diff;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_diff", 64'(diff), 64'(d_hold));
      chk("bp.hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.ov_drop", 64'(out_valid), 64'd0);
    chk("bp.rdy_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.second_taken", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2.latency", 64'(lat), 64'd4);
    chk("bp2.diff", 64'(diff), 64'(ed2));
    chk("bp2.borrow", 64'(borrow), 64'(eb2));
    chk("bp2.zero", 64'(zero), 64'(ez2));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
